// File: rtl/sirv_tl_d_collector.sv
// -----------------------------------------------------------------------------
// sirv_tl_d_collector
//
// Purpose:
//   Collects the D-channel responses of a transaction that was split into
//   several smaller requests downstream. After a descriptor gives the beat
//   count and the original request size, AccessAckData beats pass straight
//   through. Non-data acks are swallowed until the final one, which is
//   forwarded as the single ack for the whole transaction. Forwarded beats
//   carry the original size instead of the fragment size.
//
// Configuration:
//   SIRV_TL_D_COLLECT_ERR_EN - when defined, errors on swallowed acks are
//   accumulated and ORed into the error of every later forwarded beat. When
//   undefined, the forwarded error is the downstream error alone.
//
// Ports:
//   clock, reset          - single clock; synchronous active-high reset
//   io_frag_*             - descriptor handshake (beats = responses - 1,
//                           size = original request size)
//   io_in_*               - downstream D-channel (ready out, valid/bits in)
//   io_out_*              - upstream D-channel (ready in, valid/bits out)
// -----------------------------------------------------------------------------
module sirv_tl_d_collector #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic             io_frag_ready,
  input  logic             io_frag_valid,
  input  logic [CNT_W-1:0] io_frag_beats,
  input  logic [2:0]       io_frag_size,
  output logic             io_in_ready,
  input  logic             io_in_valid,
  input  logic [2:0]       io_in_bits_opcode,
  input  logic [1:0]       io_in_bits_param,
  input  logic [2:0]       io_in_bits_size,
  input  logic [1:0]       io_in_bits_source,
  input  logic             io_in_bits_sink,
  input  logic [1:0]       io_in_bits_addr_lo,
  input  logic [31:0]      io_in_bits_data,
  input  logic             io_in_bits_error,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [2:0]       io_out_bits_opcode,
  output logic [1:0]       io_out_bits_param,
  output logic [2:0]       io_out_bits_size,
  output logic [1:0]       io_out_bits_source,
  output logic             io_out_bits_sink,
  output logic [1:0]       io_out_bits_addr_lo,
  output logic [31:0]      io_out_bits_data,
  output logic             io_out_bits_error
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [2:0]       r_size;

  logic w_is_data;
  logic w_last;
  logic w_swallow;
  logic w_frag_fire;
  logic w_in_fire;
  logic w_err_acc;
  logic w_unused;

  assign w_is_data   = (io_in_bits_opcode == 3'd1);
  assign w_last      = (r_remaining == {CNT_W{1'b0}});
  // Only non-data acks before the final beat are absorbed; the final ack is
  // the one that reports completion upstream.
  assign w_swallow   = ~w_is_data & ~w_last;
  assign w_frag_fire = io_frag_valid & io_frag_ready;
  assign w_in_fire   = io_in_valid & io_in_ready;

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt   = r_state;
    io_frag_ready = 1'b0;
    io_in_ready   = 1'b0;
    io_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        io_frag_ready = 1'b1;
        if (io_frag_valid) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (w_swallow) begin
          io_in_ready  = 1'b1;
          io_out_valid = 1'b0;
        end else begin
          // Pass-through: valid never looks at out_ready
          io_in_ready  = io_out_ready;
          io_out_valid = io_in_valid;
        end
        // The final beat is never swallowed, so its fire needs out_ready
        if (io_in_valid && io_out_ready && w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, remaining-beat counter and latched original size
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= {CNT_W{1'b0}};
      r_size      <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_frag_fire) begin
        r_remaining <= io_frag_beats;
        r_size      <= io_frag_size;
      end else if (w_in_fire && !w_last) begin
        // Guarded by !w_last, so the counter never wraps
        r_remaining <= r_remaining - CNT_W'(1);
      end else begin
        r_remaining <= r_remaining;
        r_size      <= r_size;
      end
    end
  end

`ifdef SIRV_TL_D_COLLECT_ERR_EN
  logic r_err_acc;

  // Sticky error from swallowed acks, cleared per descriptor
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_acc <= 1'b0;
    end else if (w_frag_fire) begin
      r_err_acc <= 1'b0;
    end else if (w_in_fire && w_swallow) begin
      r_err_acc <= r_err_acc | io_in_bits_error;
    end else begin
      r_err_acc <= r_err_acc;
    end
  end

  assign w_err_acc = r_err_acc;
`else
  assign w_err_acc = 1'b0;
`endif

  // Fields come straight from the held input bits, so they stay stable
  // while the upstream side stalls.
  assign io_out_bits_opcode  = io_in_bits_opcode;
  assign io_out_bits_param   = io_in_bits_param;
  assign io_out_bits_size    = r_size;
  assign io_out_bits_source  = io_in_bits_source;
  assign io_out_bits_sink    = io_in_bits_sink;
  assign io_out_bits_addr_lo = io_in_bits_addr_lo;
  assign io_out_bits_data    = io_in_bits_data;
  assign io_out_bits_error   = io_in_bits_error | w_err_acc;

  // The fragment size is replaced by the latched original size
  assign w_unused = ^io_in_bits_size;

endmodule

// File: tb/tb_sirv_tl_d_collector.sv
// -----------------------------------------------------------------------------
// tb_sirv_tl_d_collector
//
// Directed scenarios plus randomized transactions for sirv_tl_d_collector.
// Expected values come from a transaction-level view: beat i of an
// (n+1)-beat transaction is forwarded when it carries data or is the last
// beat; forwarded beats carry the descriptor size and, with
// SIRV_TL_D_COLLECT_ERR_EN, the OR of errors seen on earlier swallowed beats.
// -----------------------------------------------------------------------------
module tb_sirv_tl_d_collector;

  localparam int CNT_W = 4;
`ifdef SIRV_TL_D_COLLECT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             io_frag_ready;
  logic             io_frag_valid;
  logic [CNT_W-1:0] io_frag_beats;
  logic [2:0]       io_frag_size;
  logic             io_in_ready;
  logic             io_in_valid;
  logic [2:0]       io_in_bits_opcode;
  logic [1:0]       io_in_bits_param;
  logic [2:0]       io_in_bits_size;
  logic [1:0]       io_in_bits_source;
  logic             io_in_bits_sink;
  logic [1:0]       io_in_bits_addr_lo;
  logic [31:0]      io_in_bits_data;
  logic             io_in_bits_error;
  logic             io_out_ready;
  logic             io_out_valid;
  logic [2:0]       io_out_bits_opcode;
  logic [1:0]       io_out_bits_param;
  logic [2:0]       io_out_bits_size;
  logic [1:0]       io_out_bits_source;
  logic             io_out_bits_sink;
  logic [1:0]       io_out_bits_addr_lo;
  logic [31:0]      io_out_bits_data;
  logic             io_out_bits_error;

  int vectors     = 0;
  int miscompares = 0;

  // {frag_ready, in_ready, out_valid}
  wire [2:0]  w_hs    = {io_frag_ready, io_in_ready, io_out_valid};
  wire [45:0] w_obits = {io_out_bits_opcode, io_out_bits_param, io_out_bits_size,
                         io_out_bits_source, io_out_bits_sink, io_out_bits_addr_lo,
                         io_out_bits_data, io_out_bits_error};

  always #5 clock = ~clock;

  sirv_tl_d_collector #(.CNT_W(CNT_W)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_frag_ready       (io_frag_ready),
    .io_frag_valid       (io_frag_valid),
    .io_frag_beats       (io_frag_beats),
    .io_frag_size        (io_frag_size),
    .io_in_ready         (io_in_ready),
    .io_in_valid         (io_in_valid),
    .io_in_bits_opcode   (io_in_bits_opcode),
    .io_in_bits_param    (io_in_bits_param),
    .io_in_bits_size     (io_in_bits_size),
    .io_in_bits_source   (io_in_bits_source),
    .io_in_bits_sink     (io_in_bits_sink),
    .io_in_bits_addr_lo  (io_in_bits_addr_lo),
    .io_in_bits_data     (io_in_bits_data),
    .io_in_bits_error    (io_in_bits_error),
    .io_out_ready        (io_out_ready),
    .io_out_valid        (io_out_valid),
    .io_out_bits_opcode  (io_out_bits_opcode),
    .io_out_bits_param   (io_out_bits_param),
    .io_out_bits_size    (io_out_bits_size),
    .io_out_bits_source  (io_out_bits_source),
    .io_out_bits_sink    (io_out_bits_sink),
    .io_out_bits_addr_lo (io_out_bits_addr_lo),
    .io_out_bits_data    (io_out_bits_data),
    .io_out_bits_error   (io_out_bits_error)
  );

  // Expected upstream fields: side fields are derived from the data word
  // exactly as put_beat derives the driven ones.
  function automatic logic [45:0] exp_bits(input logic [2:0] op, input logic [2:0] sz,
                                           input logic [31:0] d, input logic e);
    return {op, d[1:0], sz, d[3:2], d[4], d[6:5], d, e};
  endfunction

  // Drive one downstream beat at the falling edge and let outputs settle
  task automatic put_beat(input logic v, input logic [2:0] op, input logic err,
                          input logic [31:0] d, input logic rdy);
    @(negedge clock);
    io_in_valid        = v;
    io_in_bits_opcode  = op;
    io_in_bits_param   = d[1:0];
    io_in_bits_size    = d[9:7];
    io_in_bits_source  = d[3:2];
    io_in_bits_sink    = d[4];
    io_in_bits_addr_lo = d[6:5];
    io_in_bits_data    = d;
    io_in_bits_error   = err;
    io_out_ready       = rdy;
    #1;
  endtask

  // Present a descriptor for one clock (DUT is expected to be idle)
  task automatic go_frag(input logic [CNT_W-1:0] b, input logic [2:0] sz);
    @(negedge clock);
    io_in_valid   = 1'b0;
    io_frag_valid = 1'b1;
    io_frag_beats = b;
    io_frag_size  = sz;
    @(posedge clock);
    #1;
    io_frag_valid = 1'b0;
  endtask

  // Quiet cycle: no downstream beat, upstream not ready
  task automatic go_idle();
    @(negedge clock);
    io_in_valid      = 1'b0;
    io_in_bits_error = 1'b0;
    io_out_ready     = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    io_in_valid       = 1'b1;
    io_in_bits_opcode = 3'd0;
    io_in_bits_error  = 1'b0;
    io_out_ready      = 1'b1;
    #1;
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL reset_handshake: got %b want %b", w_hs, 3'b100);
    end
    vectors++;
    if ({io_out_bits_size, io_out_bits_error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_size_err: got %h want %h", {io_out_bits_size, io_out_bits_error}, 4'h0);
    end
    @(negedge clock);
    reset       = 1'b0;
    io_in_valid = 1'b0;
    @(negedge clock);
    #1;
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL post_reset_idle: got %b want %b", w_hs, 3'b100);
    end
  endtask

  task automatic test_ack_collapse();
    logic [31:0] d;
    go_frag(4'd3, 3'd4);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      put_beat(1'b1, 3'd0, 1'b0, d, 1'b1);
      vectors++;
      if (w_hs !== ((i < 3) ? 3'b010 : 3'b011)) begin
        miscompares++;
        $display("FAIL collapse_hs beat %0d: got %b want %b", i, w_hs, (i < 3) ? 3'b010 : 3'b011);
      end
      if (i == 3) begin
        vectors++;
        if (w_obits !== exp_bits(3'd0, 3'd4, d, 1'b0)) begin
          miscompares++;
          $display("FAIL collapse_bits: got %h want %h", w_obits, exp_bits(3'd0, 3'd4, d, 1'b0));
        end
      end
    end
    go_idle();
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL collapse_idle: got %b want %b", w_hs, 3'b100);
    end
  endtask

  task automatic test_data_pass();
    logic [31:0] d [3];
    logic        r [3];
    d[0] = 32'hA5A5A5A5; d[1] = 32'hA5A5A5A5; d[2] = 32'h5A5A5A5A;
    r[0] = 1'b0;         r[1] = 1'b1;         r[2] = 1'b1;
    go_frag(4'd1, 3'd5);
    for (int i = 0; i < 3; i++) begin
      put_beat(1'b1, 3'd1, 1'b0, d[i], r[i]);
      vectors++;
      if (w_hs !== {1'b0, r[i], 1'b1}) begin
        miscompares++;
        $display("FAIL data_hs step %0d: got %b want %b", i, w_hs, {1'b0, r[i], 1'b1});
      end
      vectors++;
      if (w_obits !== exp_bits(3'd1, 3'd5, d[i], 1'b0)) begin
        miscompares++;
        $display("FAIL data_bits step %0d: got %h want %h", i, w_obits, exp_bits(3'd1, 3'd5, d[i], 1'b0));
      end
    end
    go_idle();
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL data_idle: got %b want %b", w_hs, 3'b100);
    end
  endtask

  task automatic test_err_acc();
    logic [31:0] d;
    logic [2:0]  errs;
    errs = 3'b010;
    go_frag(4'd2, 3'd3);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      put_beat(1'b1, 3'd0, errs[i], d, 1'b1);
      vectors++;
      if (w_hs !== ((i < 2) ? 3'b010 : 3'b011)) begin
        miscompares++;
        $display("FAIL err_hs beat %0d: got %b want %b", i, w_hs, (i < 2) ? 3'b010 : 3'b011);
      end
      if (i == 2) begin
        vectors++;
        if (w_obits !== exp_bits(3'd0, 3'd3, d, ERR_EN)) begin
          miscompares++;
          $display("FAIL err_bits: got %h want %h", w_obits, exp_bits(3'd0, 3'd3, d, ERR_EN));
        end
      end
    end
    go_idle();
  endtask

  task automatic test_stall();
    logic [31:0] d;
    go_frag(4'd1, 3'd2);
    put_beat(1'b1, 3'd0, 1'b0, $urandom, 1'b0);
    vectors++;
    if (w_hs !== 3'b010) begin
      miscompares++; $display("FAIL stall_swallow: got %b want %b", w_hs, 3'b010);
    end
    d = $urandom;
    for (int c = 0; c < 6; c++) begin
      put_beat(1'b1, 3'd0, 1'b0, d, (c == 5) ? 1'b1 : 1'b0);
      vectors++;
      if (w_hs !== ((c == 5) ? 3'b011 : 3'b001)) begin
        miscompares++;
        $display("FAIL stall_hs cycle %0d: got %b want %b", c, w_hs, (c == 5) ? 3'b011 : 3'b001);
      end
      vectors++;
      if (w_obits !== exp_bits(3'd0, 3'd2, d, 1'b0)) begin
        miscompares++;
        $display("FAIL stall_bits cycle %0d: got %h want %h", c, w_obits, exp_bits(3'd0, 3'd2, d, 1'b0));
      end
    end
    go_idle();
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL stall_idle: got %b want %b", w_hs, 3'b100);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    go_frag(4'd3, 3'd1);
    for (int i = 0; i < 2; i++) begin
      put_beat(1'b1, 3'd0, 1'b1, $urandom, 1'b1);
      vectors++;
      if (w_hs !== 3'b010) begin
        miscompares++; $display("FAIL rstmid_swallow beat %0d: got %b want %b", i, w_hs, 3'b010);
      end
    end
    @(negedge clock);
    io_in_valid      = 1'b0;
    io_in_bits_error = 1'b0;
    reset            = 1'b1;
    @(posedge clock);
    #1;
    vectors++;
    if ({w_hs, io_out_bits_size, io_out_bits_error} !== 7'b100_000_0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got %b want %b", {w_hs, io_out_bits_size, io_out_bits_error}, 7'b100_000_0);
    end
    reset = 1'b0;
    go_frag(4'd0, 3'd6);
    d = $urandom;
    put_beat(1'b1, 3'd0, 1'b0, d, 1'b1);
    vectors++;
    if ({w_hs, w_obits} !== {3'b011, exp_bits(3'd0, 3'd6, d, 1'b0)}) begin
      miscompares++;
      $display("FAIL rstmid_single: got %h want %h", {w_hs, w_obits}, {3'b011, exp_bits(3'd0, 3'd6, d, 1'b0)});
    end
    go_idle();
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL rstmid_idle: got %b want %b", w_hs, 3'b100);
    end
  endtask

  task automatic test_frag_hold();
    logic [31:0] d;
    go_frag(4'd1, 3'd7);
    put_beat(1'b1, 3'd0, 1'b0, $urandom, 1'b1);
    // Next descriptor already waiting while the final beat goes through
    io_frag_valid = 1'b1;
    io_frag_beats = 4'd0;
    io_frag_size  = 3'd2;
    put_beat(1'b1, 3'd0, 1'b0, $urandom, 1'b1);
    vectors++;
    if (w_hs !== 3'b011) begin
      miscompares++; $display("FAIL hold_final_beat: got %b want %b", w_hs, 3'b011);
    end
    @(negedge clock);
    io_in_valid = 1'b0;
    #1;
    vectors++;
    if (w_hs !== 3'b100) begin
      miscompares++; $display("FAIL hold_idle_accept: got %b want %b", w_hs, 3'b100);
    end
    @(posedge clock);
    #1;
    io_frag_valid = 1'b0;
    d = $urandom;
    put_beat(1'b1, 3'd1, 1'b0, d, 1'b1);
    vectors++;
    if ({w_hs, w_obits} !== {3'b011, exp_bits(3'd1, 3'd2, d, 1'b0)}) begin
      miscompares++;
      $display("FAIL hold_new_txn: got %h want %h", {w_hs, w_obits}, {3'b011, exp_bits(3'd1, 3'd2, d, 1'b0)});
    end
    go_idle();
  endtask

  task automatic test_random();
    int          n;
    int          tries;
    logic [2:0]  sz;
    logic [2:0]  op;
    logic        err;
    logic        acc;
    logic        fwd;
    logic        v;
    logic        rdy;
    logic        e_ir;
    logic        fired;
    logic [31:0] d;
    for (int t = 0; t < 30; t++) begin
      n  = (t == 0) ? 0 : (t == 1) ? 15 : int'($urandom_range(0, 15));
      sz = 3'($urandom_range(0, 7));
      go_frag(CNT_W'(n), sz);
      acc = 1'b0;
      for (int i = 0; i <= n; i++) begin
        if ($urandom_range(0, 1) == 1) op = 3'd1;
        else op = 3'($urandom_range(0, 6));
        if (op >= 3'd1 && $urandom_range(0, 1) == 0) op = op + 3'd1;
        err   = 1'($urandom_range(0, 1));
        d     = $urandom;
        fwd   = (op == 3'd1) || (i == n);
        fired = 1'b0;
        tries = 0;
        while (!fired) begin
          v   = (tries < 10) ? ($urandom_range(0, 4) != 0) : 1'b1;
          rdy = (tries < 10) ? ($urandom_range(0, 3) != 0) : 1'b1;
          put_beat(v, op, err, d, rdy);
          e_ir = fwd ? rdy : 1'b1;
          vectors++;
          if (w_hs !== {1'b0, e_ir, fwd & v}) begin
            miscompares++;
            $display("FAIL rand_hs txn %0d beat %0d: got %b want %b", t, i, w_hs, {1'b0, e_ir, fwd & v});
          end
          if (fwd && v) begin
            vectors++;
            if (w_obits !== exp_bits(op, sz, d, err | (ERR_EN & acc))) begin
              miscompares++;
              $display("FAIL rand_bits txn %0d beat %0d: got %h want %h", t, i, w_obits,
                       exp_bits(op, sz, d, err | (ERR_EN & acc)));
            end
          end
          fired = v & e_ir;
          tries++;
        end
        if (!fwd) acc = acc | err;
      end
      go_idle();
      vectors++;
      if (w_hs !== 3'b100) begin
        miscompares++; $display("FAIL rand_idle txn %0d: got %b want %b", t, w_hs, 3'b100);
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    io_frag_valid      = 1'b0;
    io_frag_beats      = 4'd0;
    io_frag_size       = 3'd0;
    io_in_valid        = 1'b0;
    io_in_bits_opcode  = 3'd0;
    io_in_bits_param   = 2'd0;
    io_in_bits_size    = 3'd0;
    io_in_bits_source  = 2'd0;
    io_in_bits_sink    = 1'b0;
    io_in_bits_addr_lo = 2'd0;
    io_in_bits_data    = 32'd0;
    io_in_bits_error   = 1'b0;
    io_out_ready       = 1'b0;
    test_reset();
    test_ack_collapse();
    test_data_pass();
    test_err_acc();
    test_stall();
    test_reset_mid();
    test_frag_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
